// File: rtl/inert_spi_seq.sv
// Sequencer in front of the SPI master: powers up and configures the inertial sensor, then
// reads a 16-bit yaw rate (low byte, then high byte) on every data-ready interrupt.
module inert_spi_seq #(
    parameter int INIT_WAIT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic        init_done,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    typedef enum logic [2:0] {
        INIT_WAIT = 3'd0,
        CFG_INT   = 3'd1,
        CFG_GYR   = 3'd2,
        CFG_RND   = 3'd3,
        WAIT_INT  = 3'd4,
        RD_YL     = 3'd5,
        RD_YH     = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_nxt;
    logic [INIT_WAIT_W-1:0] r_timer;
    logic                   r_int_ff1;
    logic                   r_int_s;
    logic                   r_done_q;
    logic [7:0]             r_lo_byte;

    logic                   w_cmplt;
    logic                   w_start;
    logic [15:0]            w_cmd;
    logic                   w_init_set;
    logic                   w_lo_cap;
    logic                   w_yaw_cap;

    // spi_done is held high between transfers, so only its rising edge marks completion
    assign w_cmplt = spi_done & ~r_done_q;

    always_comb begin
        w_nxt      = r_state;
        w_start    = 1'b0;
        w_cmd      = spi_cmd;
        w_init_set = 1'b0;
        w_lo_cap   = 1'b0;
        w_yaw_cap  = 1'b0;
        case (r_state)
            INIT_WAIT: begin
                if (&r_timer) begin
                    w_nxt   = CFG_INT;
                    w_start = 1'b1;
                    w_cmd   = 16'h0D02;
                end
            end
            CFG_INT: begin
                if (w_cmplt) begin
                    w_nxt   = CFG_GYR;
                    w_start = 1'b1;
                    w_cmd   = 16'h1160;
                end
            end
            CFG_GYR: begin
                if (w_cmplt) begin
                    w_nxt   = CFG_RND;
                    w_start = 1'b1;
                    w_cmd   = 16'h1440;
                end
            end
            CFG_RND: begin
                if (w_cmplt) begin
                    w_nxt      = WAIT_INT;
                    w_init_set = 1'b1;
                end
            end
            WAIT_INT: begin
                if (r_int_s) begin
                    w_nxt   = RD_YL;
                    w_start = 1'b1;
                    w_cmd   = 16'hA600;
                end
            end
            RD_YL: begin
                if (w_cmplt) begin
                    w_nxt    = RD_YH;
                    w_start  = 1'b1;
                    w_cmd    = 16'hA700;
                    w_lo_cap = 1'b1;
                end
            end
            RD_YH: begin
                if (w_cmplt) begin
                    w_nxt     = WAIT_INT;
                    w_yaw_cap = 1'b1;
                end
            end
            default: w_nxt = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= INIT_WAIT;
            r_timer   <= '0;
            r_int_ff1 <= 1'b0;
            r_int_s   <= 1'b0;
            r_done_q  <= 1'b0;
            spi_wrt   <= 1'b0;
            spi_cmd   <= 16'h0000;
            init_done <= 1'b0;
            yaw_rt    <= 16'h0000;
            vld       <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_int_ff1 <= INT;
            r_int_s   <= r_int_ff1;
            r_done_q  <= spi_done;
            spi_wrt   <= w_start;
            spi_cmd   <= w_cmd;
            vld       <= w_yaw_cap;
            // timer saturates once the power-up wait has elapsed
            if ((r_state == INIT_WAIT) && !(&r_timer)) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_init_set) begin
                init_done <= 1'b1;
            end
            if (w_yaw_cap) begin
                yaw_rt <= {spi_rd[7:0], r_lo_byte};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_lo_cap) begin
            r_lo_byte <= spi_rd[7:0];
        end
    end

endmodule

// File: tb/tb_inert_spi_seq.sv
// Bench for inert_spi_seq: SPI engine model with byte queues, a yaw reference computed from the
// served bytes, a table of burst vectors, randomized bursts and reset/interrupt corner sequences.
module tb_inert_spi_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd = 16'h0000;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        init_done;
    logic [15:0] yaw_rt;
    logic        vld;

    inert_spi_seq #(.INIT_WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .spi_done(spi_done), .spi_rd(spi_rd),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .init_done(init_done), .yaw_rt(yaw_rt), .vld(vld)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // SPI engine model and monitor state
    int          cyc = 0, cnt = 0;
    int          wrt_cnt = 0, vld_cnt = 0, a600_cnt = 0;
    int          adj_viol = 0, vld_long = 0, hold_viol = 0, early_rd = 0;
    int          done_cyc = -10, init_cyc = -10, a600_cyc = -10;
    logic [15:0] cur_cmd = 16'h0000;
    logic [15:0] lo_q[$];
    logic [15:0] hi_q[$];
    logic [15:0] cmd_log[$];
    logic [15:0] w;
    logic [7:0]  srv_lo = 8'h00, srv_hi = 8'h00;
    logic        prev_wrt = 1'b0, prev_vld = 1'b0, prev_rst = 1'b0, prev_init = 1'b0;
    logic [15:0] prev_yaw = 16'h0000;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                spi_done = 1'b0;
                cnt      = 0;
            end else begin
                if (spi_wrt) begin
                    wrt_cnt++;
                    if (prev_wrt) adj_viol++;
                    cmd_log.push_back(spi_cmd);
                    cur_cmd  = spi_cmd;
                    spi_done = 1'b0;
                    cnt      = 40;
                    if (spi_cmd == 16'hA600) begin
                        a600_cnt++;
                        a600_cyc = cyc;
                        if (!init_done) early_rd++;
                    end
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        spi_done = 1'b1;
                        done_cyc = cyc;
                        if (cur_cmd == 16'hA600) begin
                            w = (lo_q.size() > 0) ? lo_q.pop_front() : 16'h0000;
                            srv_lo = w[7:0];
                        end else if (cur_cmd == 16'hA700) begin
                            w = (hi_q.size() > 0) ? hi_q.pop_front() : 16'h0000;
                            srv_hi = w[7:0];
                        end else begin
                            w = 16'($urandom);
                        end
                        spi_rd = w;
                    end
                end
                if (vld) begin
                    vld_cnt++;
                    chk("vld_latency", cyc, done_cyc + 1);
                    chk("yaw_model", int'($signed(yaw_rt)), int'($signed(srv_hi)) * 256 + int'(srv_lo));
                end
                if (vld && prev_vld) vld_long++;
                if (prev_rst && !vld && (yaw_rt != prev_yaw)) hold_viol++;
                if (init_done && !prev_init) init_cyc = cyc;
            end
            prev_wrt  = rst_n & spi_wrt;
            prev_vld  = rst_n & vld;
            prev_rst  = rst_n;
            prev_init = init_done;
            prev_yaw  = yaw_rt;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wrt(input int target, input int budget, input string name);
        int n = 0;
        while (wrt_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(wrt_cnt >= target), 1);
    endtask

    task automatic wait_vld(input int target, input int budget, input int drop_at, input string name);
        int n = 0;
        while (vld_cnt < target && n < budget) begin
            tick();
            n++;
            if (wrt_cnt >= drop_at) INT = 1'b0;
        end
        chk(name, int'(vld_cnt >= target), 1);
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        while (!init_done && n < budget) begin
            tick();
            n++;
        end
        chk("init_done_reached", int'(init_done), 1);
    endtask

    task automatic measure_first_wrt(input string name);
        int n = 0;
        while (!spi_wrt && n < 100) begin
            tick();
            n++;
        end
        chk(name, n, 16);
        chk({name, "_cmd"}, int'(spi_cmd), 16'h0D02);
    endtask

    typedef struct {
        logic [15:0] lo_w;
        logic [15:0] hi_w;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[3];
    int   bw, bv;

    initial begin
        tbl[0] = '{16'h0080, 16'h00FF, 16'hFF80};
        tbl[1] = '{16'h0001, 16'h0000, 16'h0001};
        tbl[2] = '{16'h00FF, 16'h007F, 16'h7FFF};

        // reset state
        rst_n = 1'b0;
        INT   = 1'b0;
        tick(); tick();
        chk("rst_spi_wrt", int'(spi_wrt), 0);
        chk("rst_spi_cmd", int'(spi_cmd), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_yaw_rt", int'(yaw_rt), 0);
        chk("rst_vld", int'(vld), 0);
        rst_n = 1'b1;
        measure_first_wrt("powerup_wait");

        // configuration sequence
        wait_init(400);
        chk("cfg_wrt_count", wrt_cnt, 3);
        chk("cfg_cmd0", int'(cmd_log[0]), 16'h0D02);
        chk("cfg_cmd1", int'(cmd_log[1]), 16'h1160);
        chk("cfg_cmd2", int'(cmd_log[2]), 16'h1440);
        chk("init_latency", init_cyc, done_cyc + 1);
        chk("no_vld_during_cfg", vld_cnt, 0);
        repeat (100) tick();
        chk("idle_no_wrt", wrt_cnt, 3);

        // single burst; upper byte of spi_rd must be ignored
        bw = wrt_cnt;
        bv = vld_cnt;
        lo_q.push_back(16'hFF34);
        hi_q.push_back(16'h0012);
        INT = 1'b1;
        wait_wrt(bw + 1, 50, "burst_start");
        INT = 1'b0;
        chk("burst_cmd_lo", int'(cmd_log[bw]), 16'hA600);
        wait_wrt(bw + 2, 100, "burst_second_read");
        chk("yaw_between_reads", int'(yaw_rt), 0);
        chk("burst_cmd_hi", int'(cmd_log[bw + 1]), 16'hA700);
        wait_vld(bv + 1, 100, 1 << 30, "burst_vld");
        chk("burst_yaw", int'(yaw_rt), 16'h1234);
        repeat (60) tick();
        chk("burst_wrt_total", wrt_cnt - bw, 2);
        chk("burst_vld_total", vld_cnt - bv, 1);

        // back-to-back bursts from the vector table with INT held high
        bw = wrt_cnt;
        bv = vld_cnt;
        for (int i = 0; i < 3; i++) begin
            lo_q.push_back(tbl[i].lo_w);
            hi_q.push_back(tbl[i].hi_w);
        end
        INT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_vld(bv + i + 1, 200, bw + 6, "tbl_vld");
            chk("tbl_yaw", int'(yaw_rt), int'(tbl[i].exp));
        end
        INT = 1'b0;
        repeat (60) tick();
        chk("tbl_wrt_total", wrt_cnt - bw, 6);
        chk("tbl_vld_total", vld_cnt - bv, 3);

        // randomized back-to-back bursts against the reference model
        bw = wrt_cnt;
        bv = vld_cnt;
        for (int i = 0; i < 6; i++) begin
            lo_q.push_back(16'($urandom));
            hi_q.push_back(16'($urandom));
        end
        INT = 1'b1;
        wait_vld(bv + 6, 1200, bw + 12, "rand_vld");
        INT = 1'b0;
        repeat (60) tick();
        chk("rand_wrt_total", wrt_cnt - bw, 12);
        chk("rand_vld_total", vld_cnt - bv, 6);

        // INT held high across reset release: reads wait for init_done
        rst_n = 1'b0;
        tick(); tick();
        INT   = 1'b1;
        rst_n = 1'b1;
        wait_init(400);
        bv = a600_cnt;
        while (a600_cnt == bv && cyc < init_cyc + 10) tick();
        chk("first_rd_after_init", int'((a600_cyc > init_cyc) && (a600_cyc - init_cyc <= 3)), 1);
        lo_q.push_back(16'hFF34);
        hi_q.push_back(16'h0012);
        bv = vld_cnt;
        wait_vld(bv + 1, 200, 1 << 30, "int_early_vld");
        chk("int_early_yaw", int'(yaw_rt), 16'h1234);

        // asynchronous reset during the high-byte read of the following burst
        bw = wrt_cnt;
        wait_wrt(bw + 2, 200, "reset_target_read");
        repeat (5) tick();
        chk("pre_reset_yaw", int'(yaw_rt), 16'h1234);
        chk("pre_reset_cmd", int'(spi_cmd), 16'hA700);
        rst_n = 1'b0;
        INT   = 1'b0;
        #1;
        chk("async_rst_yaw", int'(yaw_rt), 0);
        chk("async_rst_init", int'(init_done), 0);
        chk("async_rst_wrt", int'(spi_wrt), 0);
        chk("async_rst_cmd", int'(spi_cmd), 0);
        tick(); tick();
        rst_n = 1'b1;
        measure_first_wrt("rerun_wait");
        wait_init(400);

        // invariants gathered across the whole run
        chk("adjacent_wrt", adj_viol, 0);
        chk("vld_width", vld_long, 0);
        chk("yaw_hold", hold_viol, 0);
        chk("read_before_init", early_rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
